// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable counter-based clock divider.
// It produces a registered divided waveform (CLK) and a one-cycle TICK
// strobe at the end of each period. Everything runs in the CLK_100MHz domain.
// New divisor/duty values are held as pending and are applied only at a wrap
// or while disabled, so a period that is already in progress is never cut short.
module clk_div_prog #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 2048,
  parameter int DEFAULT_DUTY = 1024
) (
  input  logic             CLK_100MHz,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic [WIDTH-1:0] DUTY,
  input  logic             DIV_LD,
  output logic             CLK,
  output logic             TICK,
  output logic [WIDTH-1:0] CNT
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DEFAULT_DUTY);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] duty_a_q, duty_a_d;
  logic [WIDTH-1:0] div_p_q, div_p_d;
  logic [WIDTH-1:0] duty_p_q, duty_p_d;
  logic             pend_q, pend_d;

  logic [WIDTH-1:0] div_clamp;
  logic [WIDTH-1:0] duty_clamp;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] duty_next;
  logic             have_new;
  logic             wrap;

  // Clamp the requested values and select the values that a reload would use.
  // A load on the same edge overrides anything already pending.
  always_comb begin
    div_clamp  = (DIV < MIN_DIV) ? MIN_DIV : DIV;
    duty_clamp = (DUTY > div_clamp) ? div_clamp : DUTY;
    div_next   = DIV_LD ? div_clamp  : div_p_q;
    duty_next  = DIV_LD ? duty_clamp : duty_p_q;
    have_new   = DIV_LD | pend_q;
    wrap       = (cnt_q == (div_a_q - ONE));
  end

  // Next-state logic: pending capture, the phase counter, outputs and reload.
  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    tick_d   = tick_q;
    div_a_d  = div_a_q;
    duty_a_d = duty_a_q;
    div_p_d  = div_p_q;
    duty_p_d = duty_p_q;
    pend_d   = pend_q;

    if (DIV_LD) begin
      div_p_d  = div_clamp;
      duty_p_d = duty_clamp;
      pend_d   = 1'b1;
    end

    if (!EN) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (have_new) begin
        div_a_d  = div_next;
        duty_a_d = duty_next;
        pend_d   = 1'b0;
      end
    end else begin
      clk_d  = (cnt_q < duty_a_q);
      tick_d = wrap;
      if (wrap) begin
        cnt_d = '0;
        if (have_new) begin
          div_a_d  = div_next;
          duty_a_d = duty_next;
          pend_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers; an asynchronous reset restores the default period and duty.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      div_a_q  <= DIV_RST;
      duty_a_q <= DUTY_RST;
      div_p_q  <= DIV_RST;
      duty_p_q <= DUTY_RST;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      div_a_q  <= div_a_d;
      duty_a_q <= duty_a_d;
      div_p_q  <= div_p_d;
      duty_p_q <= duty_p_d;
      pend_q   <= pend_d;
    end
  end

  assign CNT  = cnt_q;
  assign CLK  = clk_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed stimulus with a period scoreboard for clk_div_prog.
// The stimulus pushes the expected length and high time of every period that
// will complete. A monitor measures each period that ends with TICK and
// checks it against the next expected entry.
module tb_clk_div_prog;

  typedef struct {
    int period;
    int high;
  } period_t;

  logic        clk_100mhz;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [15:0] duty;
  logic        div_ld;
  logic        clk_out;
  logic        tick;
  logic [15:0] cnt;

  period_t exp_q[$];
  int      checks;
  int      errors;
  int      tick_seen;
  int      per_cnt;
  int      high_cnt;

  clk_div_prog #(
    .WIDTH(16),
    .DEFAULT_DIV(2048),
    .DEFAULT_DUTY(1024)
  ) dut (
    .CLK_100MHz(clk_100mhz),
    .RST_N(rst_n),
    .EN(en),
    .DIV(div),
    .DUTY(duty),
    .DIV_LD(div_ld),
    .CLK(clk_out),
    .TICK(tick),
    .CNT(cnt)
  );

  // 100 MHz system clock.
  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // Monitor: just after each rising edge, measure the running period. On TICK,
  // pop the next expected period and compare. Reset or disable starts the
  // measurement again.
  initial begin
    per_cnt   = 0;
    high_cnt  = 0;
    tick_seen = 0;
    forever begin
      @(posedge clk_100mhz);
      #1;
      if (!rst_n || !en) begin
        per_cnt  = 0;
        high_cnt = 0;
      end else begin
        per_cnt  = per_cnt + 1;
        high_cnt = high_cnt + (clk_out ? 1 : 0);
        if (tick) begin
          tick_seen = tick_seen + 1;
          if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL unexpected_tick: period %0d high %0d, no period expected", per_cnt, high_cnt);
          end else begin
            period_t e;
            e = exp_q.pop_front();
            checks = checks + 2;
            if (per_cnt != e.period) begin
              errors = errors + 1;
              $display("[TB] FAIL period: got %0d expected %0d (tick %0d)", per_cnt, e.period, tick_seen);
            end
            if (high_cnt != e.high) begin
              errors = errors + 1;
              $display("[TB] FAIL high_time: got %0d expected %0d (tick %0d)", high_cnt, e.high, tick_seen);
            end
          end
          per_cnt  = 0;
          high_cnt = 0;
        end
      end
    end
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Pulse DIV_LD for one cycle with the given request. Called at a falling edge.
  task automatic applyStimulus(input int d, input int u);
    div    = d[15:0];
    duty   = u[15:0];
    div_ld = 1'b1;
    @(negedge clk_100mhz);
    div_ld = 1'b0;
  endtask

  // Queue n identical expected periods.
  task automatic pushPeriods(input int n, input int p, input int h);
    period_t e;
    e.period = p;
    e.high   = h;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Wait at falling edges until CNT equals v, with a cycle bound.
  task automatic waitCnt(input int v, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk_100mhz);
      n = n + 1;
    end while (cnt != v[15:0] && n < limit);
    if (cnt != v[15:0]) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL wait_cnt_timeout: cnt %0d never reached %0d", cnt, v);
    end
  endtask

  // Wait until the monitor has seen at least n ticks, with a cycle bound.
  task automatic waitTicks(input int n, input int limit);
    int c;
    c = 0;
    while (tick_seen < n && c < limit) begin
      @(negedge clk_100mhz);
      c = c + 1;
    end
    if (tick_seen < n) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL wait_tick_timeout: seen %0d needed %0d", tick_seen, n);
    end
  endtask

  // Wait until every expected period has been consumed, with a cycle bound.
  task automatic waitDrain(input int limit);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      @(negedge clk_100mhz);
      c = c + 1;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL drain_timeout: %0d expected periods left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Directed sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    div    = '0;
    duty   = '0;
    div_ld = 1'b0;

    #12;
    checkOutput("reset_cnt", int'(cnt), 0);
    checkOutput("reset_clk", int'(clk_out), 0);
    checkOutput("reset_tick", int'(tick), 0);

    // Default 2048/1024; a load in the third period takes effect after it ends.
    pushPeriods(3, 2048, 1024);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    waitTicks(2, 5000);
    waitCnt(500, 3000);
    applyStimulus(4, 1);
    pushPeriods(3, 4, 1);
    waitDrain(3000);

    // DIV=0 clamps to 2 and DUTY=5 clamps to 2.
    pushPeriods(1, 4, 1);
    applyStimulus(0, 5);
    pushPeriods(2, 2, 2);
    waitDrain(100);

    // DIV=1 clamps the same way.
    pushPeriods(1, 2, 2);
    applyStimulus(1, 5);
    pushPeriods(2, 2, 2);
    waitDrain(100);

    // Duty 0, then duty equal to the divisor.
    pushPeriods(1, 2, 2);
    applyStimulus(10, 0);
    pushPeriods(2, 10, 0);
    waitDrain(100);
    pushPeriods(1, 10, 0);
    applyStimulus(10, 10);
    pushPeriods(2, 10, 10);
    waitDrain(100);

    // Two loads; the second lands on the wrap edge and wins.
    pushPeriods(1, 10, 10);
    waitCnt(3, 100);
    applyStimulus(6, 2);
    pushPeriods(3, 8, 3);
    waitCnt(9, 100);
    applyStimulus(8, 3);
    waitDrain(200);

    // Disable mid-period with a load pending; it is applied while disabled.
    waitCnt(4, 100);
    applyStimulus(8, 5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100mhz);
      checkOutput("dis_cnt", int'(cnt), 0);
      checkOutput("dis_clk", int'(clk_out), 0);
      checkOutput("dis_tick", int'(tick), 0);
    end
    pushPeriods(2, 8, 5);
    en = 1'b1;
    @(negedge clk_100mhz);
    checkOutput("first_edge_cnt", int'(cnt), 1);
    checkOutput("first_edge_clk", int'(clk_out), 1);
    waitDrain(200);

    // Asynchronous reset mid-period restores 2048/1024.
    waitCnt(3, 100);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cnt", int'(cnt), 0);
    checkOutput("async_rst_clk", int'(clk_out), 0);
    checkOutput("async_rst_tick", int'(tick), 0);
    @(negedge clk_100mhz);
    pushPeriods(1, 2048, 1024);
    rst_n = 1'b1;
    waitDrain(3000);

    repeat (3) @(negedge clk_100mhz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
